// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file writeback arbiter with load FIFO and RAW scoreboard
module regfile_writeback #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [4:0]                alu_rd,
    input  logic [31:0]               alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [4:0]                mem_rd,
    input  logic [31:0]               mem_data,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_rd,
    output logic [31:0]               busy,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      wr_ena,
    output logic [4:0]                wr_addr,
    output logic [31:0]               wr_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_rd  [DEPTH];
    logic [31:0]   fifo_dat [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [SW-1:0] starve;
    logic [SW-1:0] starve_d;
    logic          alu_ready_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          alu_win;
    logic [4:0]    head_rd;
    logic [31:0]   head_dat;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(DEPTH));
    assign mem_ready  = !fifo_full;
    assign push       = mem_valid && mem_ready;
    assign head_rd    = fifo_rd[head];
    assign head_dat   = fifo_dat[head];

    // Arbitration: a forced cycle (alu_ready low) always drains the FIFO head,
    // otherwise the ALU has priority and the FIFO takes idle cycles.
    always_comb begin
        alu_win = alu_valid && alu_ready;
        pop     = !fifo_empty && (!alu_ready || !alu_valid);
    end

    // Starvation tracking: count ALU wins over a waiting load; on the limit,
    // withhold alu_ready for one cycle so the FIFO head is guaranteed a slot.
    always_comb begin
        starve_d    = starve;
        alu_ready_d = 1'b1;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (alu_win) begin
            if (starve == SW'(STARVE_LIMIT - 1)) begin
                starve_d    = '0;
                alu_ready_d = 1'b0;
            end else begin
                starve_d = starve + SW'(1);
            end
        end
    end

    // Scoreboard update masks; register x0 never has a bit.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && (issue_rd != 5'd0)) begin
            set_mask = 32'd1 << issue_rd;
        end
        if (pop && (head_rd != 5'd0)) begin
            clr_mask = 32'd1 << head_rd;
        end
    end

    // Load FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail]  <= mem_rd;
            fifo_dat[tail] <= mem_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Starvation counter and the registered ALU handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve    <= '0;
            alu_ready <= 1'b1;
        end else begin
            starve    <= starve_d;
            alu_ready <= alu_ready_d;
        end
    end

    // Scoreboard: a new issue wins over a same-cycle retirement of the same register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
        end
    end

    // Register file write port: one cycle after the winning result; x0 is swallowed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ena  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (pop) begin
            wr_ena  <= (head_rd != 5'd0);
            wr_addr <= head_rd;
            wr_data <= head_dat;
        end else if (alu_win) begin
            wr_ena  <= (alu_rd != 5'd0);
            wr_addr <= alu_rd;
            wr_data <= alu_data;
        end else begin
            wr_ena  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - scoreboard bench for regfile_writeback
module tb_regfile_writeback;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic [2:0]  fifo_count;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q[$];

    regfile_writeback #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy(busy), .fifo_count(fifo_count),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Monitor: every write the DUT presents must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst && wr_ena) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write", wr_addr, wr_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e[36:32]));
                chk("wr_data", wr_data, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b0; alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0; issue_valid = 0; issue_rd = 0;

        // Reset state
        tick(); tick();
        chk("rst_wr_ena", 32'(wr_ena), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        chk("rst_alu_ready", 32'(alu_ready), 1);
        chk("rst_mem_ready", 32'(mem_ready), 1);
        rst = 1'b1;
        tick();

        // ALU only
        expect_wr(5'd3, 32'hDEADBEEF);
        alu_valid = 1; alu_rd = 3; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 0;
        chk("alu_wr_ena", 32'(wr_ena), 1);
        tick();
        chk("alu_idle_wr_ena", 32'(wr_ena), 0);

        // Load path with scoreboard
        expect_wr(5'd7, 32'h12345678);
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        chk("load_busy7_set", 32'(busy[7]), 1);
        tick(); tick();
        mem_valid = 1; mem_rd = 7; mem_data = 32'h12345678;
        tick();
        mem_valid = 0;
        chk("load_count_after_push", 32'(fifo_count), 1);
        chk("load_no_bypass", 32'(wr_ena), 0);
        chk("load_busy7_held", 32'(busy[7]), 1);
        tick();
        chk("load_wr_ena", 32'(wr_ena), 1);
        chk("load_busy7_clear", 32'(busy[7]), 0);
        chk("load_count_after_pop", 32'(fifo_count), 0);
        tick();

        // Starvation
        expect_wr(5'd20, 32'hA0); expect_wr(5'd20, 32'hA1); expect_wr(5'd20, 32'hA2);
        expect_wr(5'd20, 32'hA3); expect_wr(5'd9, 32'h99);  expect_wr(5'd20, 32'hA4);
        alu_valid = 1; alu_rd = 20; alu_data = 32'hA0;
        mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
        tick();
        mem_valid = 0;
        chk("starve_ready0", 32'(alu_ready), 1);
        alu_data = 32'hA1; tick();
        chk("starve_ready1", 32'(alu_ready), 1);
        alu_data = 32'hA2; tick();
        chk("starve_ready2", 32'(alu_ready), 1);
        alu_data = 32'hA3; tick();
        chk("starve_forced", 32'(alu_ready), 0);
        chk("starve_count", 32'(fifo_count), 1);
        alu_data = 32'hA4; tick();
        chk("starve_ready_back", 32'(alu_ready), 1);
        chk("starve_count_drained", 32'(fifo_count), 0);
        tick();
        alu_valid = 0;
        tick();

        // FIFO full and wrap
        for (int i = 0; i < 4; i++) expect_wr(5'd21, 32'hB0 + 32'(i));
        for (int k = 1; k <= 10; k++) expect_wr(5'(k), 32'h100 + 32'(k));
        alu_valid = 1; alu_rd = 21;
        for (int i = 0; i < 4; i++) begin
            alu_data = 32'hB0 + 32'(i);
            mem_valid = 1; mem_rd = 5'(i + 1); mem_data = 32'h100 + 32'(i + 1);
            tick();
        end
        alu_valid = 0; mem_valid = 0;
        chk("full_mem_ready", 32'(mem_ready), 0);
        chk("full_fifo_count", 32'(fifo_count), 4);
        chk("full_forced", 32'(alu_ready), 0);
        tick();
        chk("full_count_after_pop", 32'(fifo_count), 3);
        for (int k = 5; k <= 10; k++) begin
            mem_valid = 1; mem_rd = 5'(k); mem_data = 32'h100 + 32'(k);
            tick();
            chk("wrap_count", 32'(fifo_count), 3);
        end
        mem_valid = 0;
        tick(); tick(); tick();
        chk("wrap_drained", 32'(fifo_count), 0);
        tick();

        // x0 load and scoreboard collision
        mem_valid = 1; mem_rd = 0; mem_data = 32'h55;
        tick();
        mem_valid = 0;
        chk("x0_count_push", 32'(fifo_count), 1);
        tick();
        chk("x0_count_pop", 32'(fifo_count), 0);
        chk("x0_no_write", 32'(wr_ena), 0);
        expect_wr(5'd10, 32'hAA);
        issue_valid = 1; issue_rd = 10;
        tick();
        issue_valid = 0;
        chk("coll_busy10_set", 32'(busy[10]), 1);
        mem_valid = 1; mem_rd = 10; mem_data = 32'hAA;
        tick();
        mem_valid = 0;
        issue_valid = 1; issue_rd = 10;
        tick();
        issue_valid = 0;
        chk("coll_busy10_kept", 32'(busy[10]), 1);
        chk("coll_count", 32'(fifo_count), 0);
        tick();

        // Reset mid-stream
        expect_wr(5'd6, 32'hC0);
        alu_valid = 1; alu_rd = 6; alu_data = 32'hC0;
        issue_valid = 1; issue_rd = 5;
        mem_valid = 1; mem_rd = 12; mem_data = 32'h1200;
        tick();
        issue_valid = 0;
        alu_data = 32'hC1; mem_rd = 13; mem_data = 32'h1300;
        tick();
        alu_valid = 0; mem_valid = 0;
        chk("mid_pre_wr_ena", 32'(wr_ena), 1);
        chk("mid_pre_wr_addr", 32'(wr_addr), 6);
        chk("mid_pre_wr_data", wr_data, 32'hC1);
        chk("mid_pre_count", 32'(fifo_count), 2);
        chk("mid_pre_busy5", 32'(busy[5]), 1);
        #1 rst = 1'b0;
        #1;
        chk("mid_wr_ena", 32'(wr_ena), 0);
        chk("mid_count", 32'(fifo_count), 0);
        chk("mid_busy", busy, 0);
        rst = 1'b1;
        #1;
        chk("mid_mem_ready", 32'(mem_ready), 1);
        chk("mid_alu_ready", 32'(alu_ready), 1);
        tick(); tick();
        chk("post_idle_wr_ena", 32'(wr_ena), 0);

        chk("exp_queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
